// File: rtl/custom_conv_ctrl.sv
// custom_conv_ctrl: sequencer for the 2x2-output convolution datapath (kernel/feature reads, lane loads, accumulates).
// Optional build macro CONV_CTRL_WEIGHT_REUSE_EN adds reuse_w to skip reloading an already loaded kernel.
module custom_conv_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int W_BASE  = 0,
    parameter int F_BASE  = 4,
    parameter int MEM_LAT = 1,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CONV_CTRL_WEIGHT_REUSE_EN
    input  logic              reuse_w,
`endif
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic [3:0]        weight_en,
    output logic [3:0]        feature_en,
    output logic [7:0]        sel_demux,
    output logic [3:0]        acc_en
);
    localparam int WAIT_N = MEM_LAT + ALU_LAT;
    localparam int CNT_W  = $clog2(WAIT_N + 1);

    typedef enum logic [2:0] {S_IDLE, S_LD_W, S_LD_F, S_WAIT, S_ACC, S_DONE} state_t;

    state_t            r_state, w_state_nx;
    logic [1:0]        r_k, w_k_nx, r_p, w_p_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [3:0]        w_tag, w_tag_out;
    logic [3:0]        r_pipe [MEM_LAT];
    logic [1:0]        w_row, w_col;
    logic [3:0]        w_off;
    logic              w_skip_w;

`ifdef CONV_CTRL_WEIGHT_REUSE_EN
    logic r_w_valid;
    // kernel-present flag: set once a full weight load has been issued
    always_ff @(posedge clk) begin
        if (rst) r_w_valid <= 1'b0;
        else if (r_state == S_LD_W && r_k == 2'd3) r_w_valid <= 1'b1;
    end
    assign w_skip_w = reuse_w & r_w_valid;
`else
    assign w_skip_w = 1'b0;
`endif

    // feature pixel offset 3*(r+kr)+(c+kc) for output p and kernel tap k
    assign w_row = {1'b0, r_p[1]} + {1'b0, r_k[1]};
    assign w_col = {1'b0, r_p[0]} + {1'b0, r_k[0]};
    assign w_off = {1'b0, w_row, 1'b0} + {2'b00, w_row} + {2'b00, w_col};

    // state and sequencing counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_k     <= w_k_nx;
            r_p     <= w_p_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // next-state, read issue and handshake outputs
    always_comb begin
        w_state_nx = r_state;
        w_k_nx     = r_k;
        w_p_nx     = r_p;
        w_cnt_nx   = r_cnt;
        w_addr     = r_addr;
        w_tag      = '0;
        mem_rd_en  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        acc_en     = '0;
        case (r_state)
            S_IDLE: if (start) begin
                w_state_nx = w_skip_w ? S_LD_F : S_LD_W;
                w_k_nx     = '0;
                w_p_nx     = '0;
            end
            S_LD_W: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                w_addr    = ADDR_W'(W_BASE) + ADDR_W'(r_k);
                w_tag     = {2'b10, r_k};
                w_k_nx    = r_k + 2'd1;
                if (r_k == 2'd3) w_state_nx = S_LD_F;
            end
            S_LD_F: begin
                busy      = 1'b1;
                mem_rd_en = 1'b1;
                w_addr    = ADDR_W'(F_BASE) + ADDR_W'(w_off);
                w_tag     = {2'b11, r_k};
                w_k_nx    = r_k + 2'd1;
                w_cnt_nx  = '0;
                if (r_k == 2'd3) w_state_nx = S_WAIT;
            end
            S_WAIT: begin
                busy     = 1'b1;
                w_cnt_nx = r_cnt + 1'b1;
                if (r_cnt == CNT_W'(WAIT_N - 1)) w_state_nx = S_ACC;
            end
            S_ACC: begin
                busy       = 1'b1;
                acc_en     = 4'b1000 >> r_p;
                w_p_nx     = r_p + 2'd1;
                w_state_nx = (r_p == 2'd3) ? S_DONE : S_LD_F;
            end
            S_DONE: begin
                done       = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // last issued address is held while no read is in progress
    always_ff @(posedge clk) begin
        if (rst) r_addr <= '0;
        else if (mem_rd_en) r_addr <= w_addr;
    end

    // read tags ride alongside memory latency so lane enables line up with returning data
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= w_tag;
            for (int i = 1; i < MEM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign w_tag_out  = r_pipe[MEM_LAT-1];
    assign mem_addr   = mem_rd_en ? w_addr : r_addr;
    assign weight_en  = (w_tag_out[3] && !w_tag_out[2]) ? 4'b1000 >> w_tag_out[1:0] : 4'b0000;
    assign feature_en = (w_tag_out[3] && w_tag_out[2]) ? 4'b1000 >> w_tag_out[1:0] : 4'b0000;
    assign sel_demux  = (r_state == S_LD_F || r_state == S_WAIT || r_state == S_ACC) ? {4{r_p}} : 8'h00;
endmodule

// File: doc/custom_conv_ctrl.md
Name: custom_conv_ctrl

Overview:
Sequencer directly upstream of the 2x2-output convolution datapath: 4 buffer/ALU lanes, per-lane 1-to-4 demux, 4 accumulators.
- Issues memory reads for a 2x2 kernel and a 3x3 feature map.
- Generates the weight_en, feature_en, sel_demux and acc_en controls that load each lane and accumulate the four outputs c11, c12, c21, c22.
- Uses a start/busy/done handshake toward the system controller.

Parameters:
ADDR_W, 8, memory address width
W_BASE, 0, address of kernel word k (k=0..3 at W_BASE+k, row-major)
F_BASE, 4, address of feature pixel (i,j) at F_BASE+3*i+j, i,j in 0..2
MEM_LAT, 1, cycles from mem_rd_en to data valid on data_in (>=1)
ALU_LAT, 1, extra cycles after a lane's feature write before its product is valid (>=0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin one convolution; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the last accumulate has been issued
mem_addr  out  ADDR_W  read address
mem_rd_en  out  1  read strobe, one word per cycle
weight_en  out  4  one-hot weight load; bit 3-k loads lane k (lane 0 = first ALU)
feature_en  out  4  one-hot feature load; bit 3-k loads lane k
sel_demux  out  8  {s0,s1,s2,s3}, 2 bits per lane; all lanes carry the current output index p
acc_en  out  4  one-hot accumulate; bit 3-p for output p (p=0..3 is c11,c12,c21,c22)

Behaviour:
- Reset: state IDLE; all outputs 0; read-enable delay pipe cleared. Reset mid-run aborts the run immediately; done is not pulsed.
- States: IDLE -> LD_W -> LD_F -> WAIT -> ACC -> (LD_F for next p | DONE) -> IDLE.
- IDLE: start=1 moves to LD_W next cycle. start outside IDLE is ignored.
- LD_W: 4 cycles, k=0..3. mem_rd_en=1, mem_addr=W_BASE+k. The tag "weight, lane k" goes into a MEM_LAT-deep shift register. weight_en[3-k] pulses exactly MEM_LAT cycles after its read.
- LD_F for output p (r=p>>1, c=p&1): 4 cycles, k=0..3 (kr=k>>1, kc=k&1).
  - mem_addr=F_BASE+3*(r+kr)+(c+kc).
  - feature_en[3-k] pulses MEM_LAT cycles later.
  - LD_F for p=0 starts the cycle after LD_W ends; in-flight weight tags still drain correctly.
- WAIT: MEM_LAT+ALU_LAT cycles; mem_rd_en=0.
- ACC: 1 cycle; acc_en[3-p]=1. Then p++, or go to DONE if p==3.
- sel_demux = {4{p[1:0]}}, held stable from the first LD_F cycle of p through its ACC cycle. It is 0 in IDLE and LD_W.
- DONE: done=1 for 1 cycle, busy=0, then IDLE. start in the DONE cycle is ignored.
- Exclusivity: at most one bit high in each of weight_en, feature_en, acc_en per cycle; weight_en and feature_en never high together.
- mem_addr holds its last value when mem_rd_en=0.
- Timing, with start sampled at cycle 0:
  - done is high at cycle 4+4*(5+MEM_LAT+ALU_LAT)+1. Defaults give 33.
  - busy is high in cycles 1..32.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is not flagged.

Optional Feature:
Macro CONV_CTRL_WEIGHT_REUSE_EN.
- Defined:
  - Adds input port reuse_w (1 bit) and an internal flag w_valid.
  - w_valid is cleared by rst and set when LD_W completes.
  - If start is accepted with reuse_w=1 and w_valid=1, LD_W is skipped and LD_F for p=0 begins the cycle after start. done then arrives 4 cycles earlier (cycle 29 at defaults).
  - reuse_w=1 with w_valid=0 performs the normal load.
- Not defined: port absent; LD_W always runs.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, start=0 -> all outputs 0, busy=0, done=0, sel_demux=0.
2. Full run at defaults: start pulse at cycle 0 ->
   - reads at addresses 0,1,2,3 in cycles 1-4;
   - weight_en 8,4,2,1 in cycles 2-5;
   - p=0 reads 4,5,7,8 in cycles 5-8;
   - acc_en=8 in cycle 11;
   - p=3 reads 8,9,11,12;
   - acc_en=1 in cycle 32; done=1 in cycle 33 only.
3. Golden data check with the datapath model: weights 1,2,3,4 and feature pixels 1..9 -> c11=37, c12=47, c21=67, c22=77.
4. start re-pulsed in cycles 5 and 33 -> ignored; no second run; busy falls after cycle 32.
5. rst asserted in cycle 15 -> next cycle all outputs 0 and IDLE. A new start then runs a full 33-cycle sequence.
6. MEM_LAT=2, ALU_LAT=0 -> each enable arrives 2 cycles after its read; done at cycle 33. With CONV_CTRL_WEIGHT_REUSE_EN and a second start with reuse_w=1 -> no weight reads, done 4 cycles earlier.
